// File: rtl/snake_pattern_checker.sv
// snake_pattern_checker
//   Receive-side monitor for the two-digit 7-segment snake animation.
//   Registers the active-low segment pins, decodes each display pair back to
//   a phase index, locks onto the 12-step sequence and then checks step order
//   and phase period. Counts sequence errors (saturating) and completed laps.
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   display1    digit-1 segments, active-low, bit 0 = seg a .. bit 6 = seg g
//   display2    digit-2 segments, active-low
//   locked      1 while tracking a valid sequence
//   step        last accepted phase index 0..ITER_N-1
//   err_pulse   one-cycle pulse on sequence error or timeout
//   period_err  one-cycle pulse when a phase lasted the wrong number of cycles
//   err_count   number of err_pulse events, saturates at all-ones
//   lap_count   completed laps (step ITER_N-1 -> 0), wraps
module snake_pattern_checker #(
  parameter int unsigned TICKS_PER_PHASE = 10,
  parameter int unsigned ITER_N          = 12,
  parameter int unsigned ERR_CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [0:6]           display1,
  input  logic [0:6]           display2,
  output logic                 locked,
  output logic [3:0]           step,
  output logic                 err_pulse,
  output logic                 period_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [7:0]           lap_count
);

  localparam int unsigned IVL_MAX = 2 * TICKS_PER_PHASE;
  localparam int unsigned IVL_W   = $clog2(IVL_MAX + 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  // All segments off: never a table entry, so reset cannot fake a change.
  localparam logic [0:6] BLANK = 7'b1111111;

  logic [0:6]           s1, s2, p1, p2;
  logic [0:0]           state, state_n;
  logic [3:0]           exp_idx, exp_n;
  logic [IVL_W-1:0]     ivl, ivl_n;
  logic                 locked_n, err_pulse_n, period_err_n;
  logic [3:0]           step_n;
  logic [ERR_CNT_W-1:0] err_count_n;
  logic [7:0]           lap_count_n;
  logic                 change_c, match_c, hit_c, raise_err_c;
  logic [3:0]           idx_c;

  // Pattern table decode: returns {match, idx}; left digit string is seg a first.
  function automatic logic [4:0] pat_lookup(input logic [13:0] pat);
    logic [4:0] r;
    r = 5'b0;
    case (pat)
      14'b0001101_0000000: r = {1'b1, 4'd0};
      14'b0001100_0001000: r = {1'b1, 4'd1};
      14'b0001000_0011000: r = {1'b1, 4'd2};
      14'b0000000_0011001: r = {1'b1, 4'd3};
      14'b0000001_0010001: r = {1'b1, 4'd4};
      14'b0000011_0000001: r = {1'b1, 4'd5};
      14'b1000011_0000000: r = {1'b1, 4'd6};
      14'b1000010_1000000: r = {1'b1, 4'd7};
      14'b1000000_1100000: r = {1'b1, 4'd8};
      14'b0000000_1100001: r = {1'b1, 4'd9};
      14'b0000001_0100001: r = {1'b1, 4'd10};
      14'b0000101_0000001: r = {1'b1, 4'd11};
      default:             r = 5'b0;
    endcase
    return r;
  endfunction

  // Successor index, wrapping at ITER_N rather than at 2^4.
  function automatic logic [3:0] next_idx(input logic [3:0] i);
    return (32'(i) == ITER_N - 1) ? 4'd0 : i + 4'd1;
  endfunction

  // Next-state and output decode.
  always_comb begin
    {match_c, idx_c} = pat_lookup({s1, s2});
    change_c     = ({s1, s2} != {p1, p2});
    hit_c        = match_c && (idx_c == exp_idx);
    raise_err_c  = 1'b0;
    state_n      = state;
    locked_n     = locked;
    step_n       = step;
    exp_n        = exp_idx;
    err_pulse_n  = 1'b0;
    period_err_n = 1'b0;
    err_count_n  = err_count;
    lap_count_n  = lap_count;
    if (change_c)                 ivl_n = '0;
    else if (32'(ivl) == IVL_MAX) ivl_n = ivl;
    else                          ivl_n = ivl + IVL_W'(1);

    case (state)
      IDLE: begin
        // Unknown patterns are ignored while searching.
        if (change_c && match_c) begin
          state_n  = LOCKED;
          locked_n = 1'b1;
          step_n   = idx_c;
          exp_n    = next_idx(idx_c);
        end
      end
      LOCKED: begin
        if (change_c) begin
          if (hit_c) begin
            step_n       = exp_idx;
            exp_n        = next_idx(exp_idx);
            period_err_n = (32'(ivl) + 32'd1 != TICKS_PER_PHASE);
            if (exp_idx == 4'd0) lap_count_n = lap_count + 8'd1;
          end else begin
            raise_err_c = 1'b1;
          end
        end else if (32'(ivl) == IVL_MAX - 1) begin
          raise_err_c = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Mismatch or timeout: a single pulse and a single count.
    if (raise_err_c) begin
      state_n     = IDLE;
      locked_n    = 1'b0;
      err_pulse_n = 1'b1;
      if (err_count != '1) err_count_n = err_count + ERR_CNT_W'(1);
    end
  end

  // Input sampling, state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= BLANK;
      s2         <= BLANK;
      p1         <= BLANK;
      p2         <= BLANK;
      state      <= IDLE;
      exp_idx    <= 4'd0;
      ivl        <= '0;
      locked     <= 1'b0;
      step       <= 4'd0;
      err_pulse  <= 1'b0;
      period_err <= 1'b0;
      err_count  <= '0;
      lap_count  <= 8'd0;
    end else begin
      s1         <= display1;
      s2         <= display2;
      p1         <= s1;
      p2         <= s2;
      state      <= state_n;
      exp_idx    <= exp_n;
      ivl        <= ivl_n;
      locked     <= locked_n;
      step       <= step_n;
      err_pulse  <= err_pulse_n;
      period_err <= period_err_n;
      err_count  <= err_count_n;
      lap_count  <= lap_count_n;
    end
  end

endmodule
